// File: rtl/led_decoder_controller.sv
// Registered BCD-to-7-segment decoder and one-hot digit select for a
// 4-digit multiplexed display, with optional one-cycle anti-ghost blanking.
module led_decoder_controller #(
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          DIG_ACTIVE_LOW = 1'b1,
  parameter int unsigned DP_POS         = 2,
  parameter bit          GHOST_BLANK    = 1'b1
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [3:0] num_in,
  input  logic [1:0] ctrl_led,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       e,
  output logic       f,
  output logic       g,
  output logic       h,
  output logic       L0,
  output logic       L1,
  output logic       L2,
  output logic       L3
);

  localparam logic [1:0] DP_IDX = 2'(DP_POS);

  logic [6:0] lit_next;
  logic       dp_next;
  logic [3:0] sel_next;
  logic [7:0] seg_q;
  logic [3:0] dig_q;
  logic [1:0] prev_led;

  // Logical lit pattern, bit 6 = a ... bit 0 = g
  always_comb begin
    lit_next = 7'b0000000;
    case (num_in)
      4'd0: lit_next = 7'b1111110;
      4'd1: lit_next = 7'b0110000;
      4'd2: lit_next = 7'b1101101;
      4'd3: lit_next = 7'b1111001;
      4'd4: lit_next = 7'b0110011;
      4'd5: lit_next = 7'b1011011;
      4'd6: lit_next = 7'b1011111;
      4'd7: lit_next = 7'b1110000;
      4'd8: lit_next = 7'b1111111;
      4'd9: lit_next = 7'b1111011;
      default: lit_next = 7'b0000000;
    endcase
  end

  assign dp_next = (ctrl_led == DP_IDX);

  // A scan-index change blanks every digit for the cycle it first appears
  always_comb begin
    sel_next = 4'b0001 << ctrl_led;
    if (GHOST_BLANK && (ctrl_led != prev_led)) begin
      sel_next = 4'b0000;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      seg_q    <= {8{SEG_ACTIVE_LOW}};
      dig_q    <= {4{DIG_ACTIVE_LOW}};
      prev_led <= 2'd0;
    end else begin
      seg_q    <= {lit_next, dp_next} ^ {8{SEG_ACTIVE_LOW}};
      dig_q    <= sel_next ^ {4{DIG_ACTIVE_LOW}};
      prev_led <= ctrl_led;
    end
  end

  assign {a, b, c, d, e, f, g, h} = seg_q;
  assign L0 = dig_q[0];
  assign L1 = dig_q[1];
  assign L2 = dig_q[2];
  assign L3 = dig_q[3];

endmodule

// File: tb/tb_led_decoder_controller.sv
// Scoreboarded bench: default instance plus an inverted-polarity,
// DP_POS=1, no-ghost-blank instance driven with the same stimulus.
module tb_led_decoder_controller;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b0;
  logic [3:0] num_in  = 4'd0;
  logic [1:0] ctrl_led = 2'd0;

  logic a1, b1, c1, d1, e1, f1, g1, h1, l0_1, l1_1, l2_1, l3_1;
  logic a2, b2, c2, d2, e2, f2, g2, h2, l0_2, l1_2, l2_2, l3_2;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] seg1;
    logic [3:0] dig1;
    logic [7:0] seg2;
    logic [3:0] dig2;
    string      name;
  } sb_t;

  sb_t        sb[$];
  sb_t        mon_e;
  logic [1:0] prev_m = 2'd0;

  led_decoder_controller dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .num_in(num_in), .ctrl_led(ctrl_led),
    .a(a1), .b(b1), .c(c1), .d(d1), .e(e1), .f(f1), .g(g1), .h(h1),
    .L0(l0_1), .L1(l1_1), .L2(l2_1), .L3(l3_1)
  );

  led_decoder_controller #(
    .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0), .DP_POS(1), .GHOST_BLANK(1'b0)
  ) dut_alt (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .num_in(num_in), .ctrl_led(ctrl_led),
    .a(a2), .b(b2), .c(c2), .d(d2), .e(e2), .f(f2), .g(g2), .h(h2),
    .L0(l0_2), .L1(l1_2), .L2(l2_2), .L3(l3_2)
  );

  wire [7:0] seg1 = {a1, b1, c1, d1, e1, f1, g1, h1};
  wire [3:0] dig1 = {l0_1, l1_1, l2_1, l3_1};
  wire [7:0] seg2 = {a2, b2, c2, d2, e2, f2, g2, h2};
  wire [3:0] dig2 = {l0_2, l1_2, l2_2, l3_2};

  always #5 sys_clk = ~sys_clk;

  function automatic logic [7:0] exp_seg(input logic [3:0] n, input logic [1:0] l,
                                         input logic sal, input logic [1:0] dpp);
    logic [6:0] lit;
    case (n)
      4'd0: lit = 7'b1111110;
      4'd1: lit = 7'b0110000;
      4'd2: lit = 7'b1101101;
      4'd3: lit = 7'b1111001;
      4'd4: lit = 7'b0110011;
      4'd5: lit = 7'b1011011;
      4'd6: lit = 7'b1011111;
      4'd7: lit = 7'b1110000;
      4'd8: lit = 7'b1111111;
      4'd9: lit = 7'b1111011;
      default: lit = 7'b0000000;
    endcase
    return {lit, (l == dpp)} ^ {8{sal}};
  endfunction

  // Bit order {L0,L1,L2,L3}
  function automatic logic [3:0] exp_dig(input logic [1:0] l, input logic [1:0] prev,
                                         input logic dal, input logic gb);
    logic [3:0] act;
    act = 4'b1000 >> l;
    if (gb && (l != prev)) act = 4'b0000;
    return act ^ {4{dal}};
  endfunction

  task automatic drive(input logic [3:0] n, input logic [1:0] l, input string nm);
    sb_t ent;
    @(negedge sys_clk);
    num_in   = n;
    ctrl_led = l;
    ent.seg1 = exp_seg(n, l, 1'b1, 2'd2);
    ent.dig1 = exp_dig(l, prev_m, 1'b1, 1'b1);
    ent.seg2 = exp_seg(n, l, 1'b0, 2'd1);
    ent.dig2 = exp_dig(l, prev_m, 1'b0, 1'b0);
    ent.name = nm;
    sb.push_back(ent);
    prev_m = l;
  endtask

  always @(posedge sys_clk) begin
    #1;
    if (!sys_rst && sb.size() > 0) begin
      mon_e = sb.pop_front();
      checks += 4;
      if (seg1 !== mon_e.seg1) begin
        errors++;
        $display("FAIL %s seg: got %b want %b", mon_e.name, seg1, mon_e.seg1);
      end
      if (dig1 !== mon_e.dig1) begin
        errors++;
        $display("FAIL %s dig: got %b want %b", mon_e.name, dig1, mon_e.dig1);
      end
      if (seg2 !== mon_e.seg2) begin
        errors++;
        $display("FAIL %s alt seg: got %b want %b", mon_e.name, seg2, mon_e.seg2);
      end
      if (dig2 !== mon_e.dig2) begin
        errors++;
        $display("FAIL %s alt dig: got %b want %b", mon_e.name, dig2, mon_e.dig2);
      end
    end
  end

  task automatic test_reset();
    #2;
    sys_rst = 1'b1;
    #1;
    checks += 4;
    if (seg1 !== 8'hFF) begin errors++; $display("FAIL reset seg: got %b want 11111111", seg1); end
    if (dig1 !== 4'hF)  begin errors++; $display("FAIL reset dig: got %b want 1111", dig1); end
    if (seg2 !== 8'h00) begin errors++; $display("FAIL reset alt seg: got %b want 00000000", seg2); end
    if (dig2 !== 4'h0)  begin errors++; $display("FAIL reset alt dig: got %b want 0000", dig2); end
    repeat (2) @(posedge sys_clk);
    #1;
    checks++;
    if (seg1 !== 8'hFF || dig1 !== 4'hF) begin
      errors++;
      $display("FAIL reset held: got %b/%b want 11111111/1111", seg1, dig1);
    end
    @(negedge sys_clk);
    sys_rst = 1'b0;
    prev_m  = 2'd0;
    drive(4'd0, 2'd0, "release");
    drive(4'd0, 2'd0, "release_hold");
  endtask

  task automatic test_digit_sweep();
    drive(4'd0, 2'd1, "sweep_enter");
    for (int i = 0; i < 10; i++) drive(4'(i), 2'd1, "sweep");
  endtask

  task automatic test_invalid();
    for (int i = 10; i < 16; i++) drive(4'(i), 2'd1, "invalid");
  endtask

  task automatic test_decimal_point();
    drive(4'd5, 2'd2, "dp_enter");
    drive(4'd5, 2'd2, "dp_lit");
    drive(4'd5, 2'd3, "dp_off");
    drive(4'd5, 2'd3, "dp_off_hold");
  endtask

  task automatic test_ghost_blank();
    drive(4'd8, 2'd0, "ghost_pre");
    drive(4'd8, 2'd0, "ghost_pre_hold");
    drive(4'd1, 2'd3, "ghost_blank");
    drive(4'd1, 2'd3, "ghost_enable");
    drive(4'd2, 2'd3, "num_change_only");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) drive(4'($urandom_range(0, 15)), 2'(i), "b2b_scan");
    for (int i = 0; i < 12; i++) drive(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), "b2b_rand");
  endtask

  task automatic test_async_reset();
    drive(4'd6, 2'd2, "pre_async");
    drive(4'd6, 2'd2, "pre_async_hold");
    @(posedge sys_clk);
    #3;
    checks++;
    if (l2_1 !== 1'b0) begin errors++; $display("FAIL async_pre L2: got %b want 0", l2_1); end
    sys_rst = 1'b1;
    #1;
    checks += 2;
    if (seg1 !== 8'hFF || dig1 !== 4'hF) begin
      errors++;
      $display("FAIL async_rst: got %b/%b want 11111111/1111", seg1, dig1);
    end
    if (seg2 !== 8'h00 || dig2 !== 4'h0) begin
      errors++;
      $display("FAIL async_rst alt: got %b/%b want 00000000/0000", seg2, dig2);
    end
    sb.delete();
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    prev_m  = 2'd0;
    drive(4'd7, 2'd1, "resume_first");
    drive(4'd7, 2'd1, "resume_hold");
    drive(4'd3, 2'd1, "resume_next");
  endtask

  initial begin
    test_reset();
    test_digit_sweep();
    test_invalid();
    test_decimal_point();
    test_ghost_blank();
    test_back_to_back();
    test_async_reset();
    repeat (2) @(posedge sys_clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
